// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, N+1 steps per product.
// Operands are widened to N+1 bits so signed and unsigned share one datapath.
module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_tc,
    input  logic [N-1:0]     in_m,
    input  logic [N-1:0]     in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic             busy
);
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N+1:0]    r_a;
    logic [N+1:0]    w_a_next;
    logic [N:0]      r_q;
    logic [N:0]      w_q_next;
    logic            r_q1;
    logic            w_q1_next;
    logic [N:0]      r_m;
    logic [N:0]      w_m_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [2*N-1:0]  r_p;
    logic [2*N-1:0]  w_p_next;

    logic [N:0]      w_m_ext;
    logic [N:0]      w_q_ext;
    logic [N+1:0]    w_m_sx;
    logic [N+1:0]    w_sum;
    logic [N+1:0]    w_a_shift;
    logic [N:0]      w_q_shift;
    logic [2*N-1:0]  w_prod;

    // The extra top bit is the sign in tc mode and zero otherwise.
    assign w_m_ext = {in_tc & in_m[N-1], in_m};
    assign w_q_ext = {in_tc & in_q[N-1], in_q};
    assign w_m_sx  = {r_m[N], r_m};

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + w_m_sx;
            2'b10:   w_sum = r_a - w_m_sx;
            default: w_sum = r_a;
        endcase
    end

    // Arithmetic right shift of {A,Q,q_1}; the product is the low 2N bits after the last shift.
    assign w_a_shift = {w_sum[N+1], w_sum[N+1:1]};
    assign w_q_shift = {w_sum[0], r_q[N:1]};
    assign w_prod    = {w_a_shift[N-2:0], w_q_shift};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_q1    <= w_q1_next;
            r_m     <= w_m_next;
            r_count <= w_count_next;
            r_p     <= w_p_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_q_next     = r_q;
        w_q1_next    = r_q1;
        w_m_next     = r_m;
        w_count_next = r_count;
        w_p_next     = r_p;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_a_next     = '0;
                    w_q_next     = w_q_ext;
                    w_q1_next    = 1'b0;
                    w_m_next     = w_m_ext;
                    w_count_next = CW'(N + 1);
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy         = 1'b1;
                w_a_next     = w_a_shift;
                w_q_next     = w_q_shift;
                w_q1_next    = r_q[0];
                w_count_next = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_p_next     = w_prod;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign out_p = r_p;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: N=8 directed cases and an exhaustive N=4 sweep.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic        v8_valid = 1'b0, v8_tc = 1'b0, v8_ready = 1'b0;
    logic [7:0]  v8_m = '0, v8_q = '0;
    logic        o8_in_ready, o8_valid, o8_busy;
    logic [15:0] o8_p;

    logic        v4_valid = 1'b0, v4_tc = 1'b0, v4_ready = 1'b0;
    logic [3:0]  v4_m = '0, v4_q = '0;
    logic        o4_in_ready, o4_valid, o4_busy;
    logic [7:0]  o4_p;

    booth_mult_seq #(.N(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .in_valid(v8_valid), .in_ready(o8_in_ready),
        .in_tc(v8_tc), .in_m(v8_m), .in_q(v8_q), .out_valid(o8_valid),
        .out_ready(v8_ready), .out_p(o8_p), .busy(o8_busy)
    );

    booth_mult_seq #(.N(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .in_valid(v4_valid), .in_ready(o4_in_ready),
        .in_tc(v4_tc), .in_m(v4_m), .in_q(v4_q), .out_valid(o4_valid),
        .out_ready(v4_ready), .out_p(o4_p), .busy(o4_busy)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] sb8[$];
    logic [7:0]  sb4[$];

    function automatic logic [15:0] ref8(input logic tc, input logic [7:0] m, input logic [7:0] q);
        int a, b, p;
        a = tc ? {{24{m[7]}}, m} : {24'd0, m};
        b = tc ? {{24{q[7]}}, q} : {24'd0, q};
        p = a * b;
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic tc, input logic [3:0] m, input logic [3:0] q);
        int a, b, p;
        a = tc ? {{28{m[3]}}, m} : {28'd0, m};
        b = tc ? {{28{q[3]}}, q} : {28'd0, q};
        p = a * b;
        return p[7:0];
    endfunction

    // Accept one operand pair, push its expected product, wait (bounded) for out_valid.
    task automatic drive8(input logic tc, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input bit toggle, output int lat);
        int cyc;
        v8_tc = tc; v8_m = m; v8_q = q; v8_valid = 1'b1;
        @(posedge clk); #1;
        sb8.push_back(exp);
        v8_valid = 1'b0;
        cyc = 0;
        while (o8_valid !== 1'b1 && cyc < 40) begin
            if (toggle) begin
                v8_valid = 1'($urandom_range(0, 1));
                v8_tc    = 1'($urandom_range(0, 1));
                v8_m     = 8'($urandom);
                v8_q     = 8'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        v8_valid = 1'b0;
        lat = cyc;
    endtask

    task automatic complete8(output logic [15:0] got);
        got = o8_p;
        v8_ready = 1'b1;
        @(posedge clk); #1;
        v8_ready = 1'b0;
    endtask

    task automatic drive4(input logic tc, input logic [3:0] m, input logic [3:0] q, output int lat);
        int cyc;
        v4_tc = tc; v4_m = m; v4_q = q; v4_valid = 1'b1;
        @(posedge clk); #1;
        sb4.push_back(ref4(tc, m, q));
        v4_valid = 1'b0;
        cyc = 0;
        while (o4_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (o8_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o8_in_ready); end
        checks++; if (o8_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", o8_valid); end
        checks++; if (o8_p !== 16'h0) begin failures++; $display("FAIL reset_out_p got=%h exp=0000", o8_p); end
        checks++; if (o8_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o8_busy); end
        checks++; if (o4_in_ready !== 1'b1 || o4_valid !== 1'b0 || o4_p !== 8'h0) begin
            failures++; $display("FAIL reset_n4 in_ready=%b out_valid=%b out_p=%h exp=1/0/00", o4_in_ready, o4_valid, o4_p);
        end
        $display("reset: in_ready=%b out_valid=%b out_p=%h busy=%b", o8_in_ready, o8_valid, o8_p, o8_busy);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [15:0] got, exp;
        int lat;
        logic        tcs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  ms[6]  = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'hFD, 8'h00};
        logic [7:0]  qs[6]  = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h05, 8'hA5};
        logic [15:0] ex[6]  = '{16'h4000, 16'hFE01, 16'h0001, 16'hC080, 16'hFFF1, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            checks++; if (o8_in_ready !== 1'b1) begin failures++; $display("FAIL directed_in_ready[%0d] got=%b exp=1", i, o8_in_ready); end
            drive8(tcs[i], ms[i], qs[i], ex[i], 1'b0, lat);
            checks++; if (lat != 9) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=9", i, lat); end
            complete8(got);
            exp = sb8.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL directed_product[%0d] got=%h exp=%h", i, got, exp); end
            checks++; if (o8_valid !== 1'b0) begin failures++; $display("FAIL directed_valid_drop[%0d] got=%b exp=0", i, o8_valid); end
            $display("txn tc=%b m=%h q=%h p=%h lat=%0d", tcs[i], ms[i], qs[i], got, lat);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] got, exp, held;
        int lat;
        drive8(1'b1, 8'h9C, 8'h37, ref8(1'b1, 8'h9C, 8'h37), 1'b0, lat);
        held = o8_p;
        for (int i = 0; i < 5; i++) begin
            v8_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (o8_valid !== 1'b1 || o8_p !== held || o8_in_ready !== 1'b0 || o8_busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure[%0d] out_valid=%b out_p=%h in_ready=%b busy=%b exp=1/%h/0/1", i, o8_valid, o8_p, o8_in_ready, o8_busy, held);
            end
        end
        v8_valid = 1'b0;
        complete8(got);
        exp = sb8.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL backpressure_product got=%h exp=%h", got, exp); end
        checks++; if (o8_p !== exp || o8_in_ready !== 1'b1) begin
            failures++; $display("FAIL backpressure_after out_p=%h in_ready=%b exp=%h/1", o8_p, o8_in_ready, exp);
        end
        $display("txn backpressure m=9c q=37 p=%h", got);
    endtask

    task automatic test_input_ignored;
        logic [15:0] got, exp;
        int lat;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] m, q;
            logic tc;
            m = 8'($urandom); q = 8'($urandom); tc = 1'($urandom_range(0, 1));
            drive8(tc, m, q, ref8(tc, m, q), 1'b1, lat);
            checks++; if (lat != 9) begin failures++; $display("FAIL ignored_latency[%0d] got=%0d exp=9", i, lat); end
            complete8(got);
            exp = sb8.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL ignored_product[%0d] got=%h exp=%h", i, got, exp); end
            $display("txn toggled tc=%b m=%h q=%h p=%h", tc, m, q, got);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [15:0] got, exp;
        int lat;
        v8_tc = 1'b1; v8_m = 8'h5A; v8_q = 8'hC3; v8_valid = 1'b1;
        @(posedge clk); #1;
        v8_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        checks++; if (o8_valid !== 1'b0 || o8_p !== 16'h0 || o8_in_ready !== 1'b1 || o8_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op out_valid=%b out_p=%h in_ready=%b busy=%b exp=0/0000/1/0", o8_valid, o8_p, o8_in_ready, o8_busy);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        drive8(1'b0, 8'h03, 8'h04, 16'h000C, 1'b0, lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL reset_recover_latency got=%0d exp=9", lat); end
        complete8(got);
        exp = sb8.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL reset_recover_product got=%h exp=%h", got, exp); end
        $display("txn after reset m=03 q=04 p=%h", got);
    endtask

    task automatic test_back_to_back;
        logic [15:0] got, exp;
        int lat;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] m, q;
            logic tc;
            m = 8'($urandom); q = 8'($urandom); tc = 1'(i % 2);
            drive8(tc, m, q, ref8(tc, m, q), 1'b0, lat);
            complete8(got);
            exp = sb8.pop_front();
            checks++; if (got !== exp || lat != 9) begin
                failures++; $display("FAIL back_to_back[%0d] got=%h lat=%0d exp=%h lat=9", i, got, lat, exp);
            end
            $display("txn b2b tc=%b m=%h q=%h p=%h", tc, m, q, got);
        end
    endtask

    task automatic test_n4_sweep;
        logic [7:0] got, exp;
        int lat;
        for (int t = 0; t < 2; t++) begin
            for (int m = 0; m < 16; m++) begin
                for (int q = 0; q < 16; q++) begin
                    drive4(1'(t), 4'(m), 4'(q), lat);
                    got = o4_p;
                    v4_ready = 1'b1;
                    @(posedge clk); #1;
                    v4_ready = 1'b0;
                    exp = sb4.pop_front();
                    checks++; if (got !== exp || lat != 5) begin
                        failures++; $display("FAIL n4_sweep tc=%0d m=%h q=%h got=%h lat=%0d exp=%h lat=5", t, m, q, got, lat, exp);
                    end
                end
            end
            $display("txn n4 sweep tc=%0d done (256 pairs)", t);
        end
        // Most-negative corner checked against the literal value as well.
        drive4(1'b1, 4'h8, 4'h8, lat);
        got = o4_p;
        v4_ready = 1'b1;
        @(posedge clk); #1;
        v4_ready = 1'b0;
        void'(sb4.pop_front());
        checks++; if (got !== 8'h40) begin failures++; $display("FAIL n4_most_negative got=%h exp=40", got); end
        $display("txn n4 tc=1 m=8 q=8 p=%h", got);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_input_ignored();
        test_reset_mid_op();
        test_back_to_back();
        test_n4_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
